// File: rtl/rv_alu_mc.sv
// RV32/RV64 integer ALU with optional M extension: single-cycle base ops and
// multiplies, iterative restoring divider, valid/ready on both sides.
module rv_alu_mc #(
    parameter int XLEN = 32,
    parameter int EN_M = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [2:0]      funct3,
    input  logic            funct7_r,
    input  logic            funct7_m,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd_out,
    output logic            busy
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, FIX, HOLD} state_t;

    state_t           state;
    logic             alive;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvsr_q;
    logic             rem_sel_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic              is_m;
    logic              is_div;
    logic              div_signed;
    logic              div_zero;
    logic              div_ovf;
    logic              long_div;
    logic              accept;
    logic [SH_W-1:0]   shamt;
    logic signed [XLEN-1:0] sra_res;
    logic              a_sgn;
    logic              b_sgn;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   fix_res;
    logic [XLEN-1:0]   quick_res;

    // alive holds in_ready low until the first clock edge after reset release
    assign in_ready = alive && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready && !flush;

    assign is_m       = (EN_M != 0) && funct7_m;
    assign is_div     = is_m && funct3[2];
    assign div_signed = !funct3[0];
    assign div_zero   = (rs2_in == '0);
    assign div_ovf    = div_signed && (rs1_in == MIN_VAL) && (rs2_in == '1);
    assign long_div   = is_div && !div_zero && !div_ovf;

    assign shamt   = rs2_in[SH_W-1:0];
    assign sra_res = $signed(rs1_in) >>> shamt;

    // Sign-extend to 2*XLEN so one multiplier covers all four variants
    assign a_sgn = (funct3[1:0] != 2'b11) && rs1_in[XLEN-1];
    assign b_sgn = (funct3[1:0] == 2'b01) && rs2_in[XLEN-1];
    assign a_ext = {{XLEN{a_sgn}}, rs1_in};
    assign b_ext = {{XLEN{b_sgn}}, rs2_in};
    assign prod  = a_ext * b_ext;

    assign abs1 = (div_signed && rs1_in[XLEN-1]) ? -rs1_in : rs1_in;
    assign abs2 = (div_signed && rs2_in[XLEN-1]) ? -rs2_in : rs2_in;

    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, dvsr_q};

    assign fix_res = rem_sel_q ? (neg_rem_q ? -rem_q : rem_q)
                               : (neg_quo_q ? -quo_q : quo_q);

    always_comb begin
        quick_res = '0;
        if (is_m) begin
            if (!funct3[2]) begin
                quick_res = (funct3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            end else if (div_zero) begin
                quick_res = funct3[1] ? rs1_in : '1;
            end else begin
                quick_res = funct3[1] ? '0 : rs1_in;
            end
        end else begin
            case (funct3)
                3'b000:  quick_res = funct7_r ? (rs1_in - rs2_in) : (rs1_in + rs2_in);
                3'b001:  quick_res = rs1_in << shamt;
                3'b010:  quick_res = {{(XLEN-1){1'b0}}, ($signed(rs1_in) < $signed(rs2_in))};
                3'b011:  quick_res = {{(XLEN-1){1'b0}}, (rs1_in < rs2_in)};
                3'b100:  quick_res = rs1_in ^ rs2_in;
                3'b101:  quick_res = funct7_r ? sra_res : (rs1_in >> shamt);
                3'b110:  quick_res = rs1_in | rs2_in;
                default: quick_res = rs1_in & rs2_in;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alive     <= 1'b0;
            out_valid <= 1'b0;
            rd_out    <= '0;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (flush) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE, HOLD: begin
                        if (accept) begin
                            if (long_div) begin
                                state     <= DIV;
                                out_valid <= 1'b0;
                                cnt       <= '0;
                                rem_q     <= '0;
                                quo_q     <= abs1;
                                dvsr_q    <= abs2;
                                rem_sel_q <= funct3[1];
                                neg_quo_q <= div_signed && (rs1_in[XLEN-1] ^ rs2_in[XLEN-1]);
                                neg_rem_q <= div_signed && rs1_in[XLEN-1];
                            end else begin
                                state     <= HOLD;
                                out_valid <= 1'b1;
                                rd_out    <= quick_res;
                            end
                        end else if ((state == HOLD) && out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    DIV: begin
                        // One restoring step: keep the trial subtraction only if it did not borrow
                        if (!div_diff[XLEN]) begin
                            rem_q <= div_diff[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q <= div_shift[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(XLEN - 1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        rd_out    <= fix_res;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
